// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the register-read stage and the execute unit.
// The master side issues operations and accepts results; the slave side is
// the execute unit itself.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_op_res;
    logic [2:0]       branch;
    logic             branch_en;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             branch_taken;

    modport master (
        output in_valid, alu_op_res, branch, branch_en, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, branch_taken
    );

    modport slave (
        input  in_valid, alu_op_res, branch, branch_en, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, branch_taken
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle integer execute unit: single-cycle ALU ops and branch compares,
// serial one-bit-per-cycle shifts, valid/ready handshake on both sides.
// The result register doubles as the shift register while a shift runs.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    alu_exec_unit_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SLTU = 4'b1000,
        OP_SLLI = 4'b1001,
        OP_SRLI = 4'b1010
    } alu_op_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             taken_q, taken_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             left_q, left_d;

    logic             accept;
    logic             is_shift;
    logic             shift_left;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             br_cond;

    // In DONE a new request is taken only when the current result is consumed.
    assign bus.in_ready     = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign accept           = bus.in_valid && bus.in_ready;
    assign bus.out_valid    = (state_q == S_DONE);
    assign bus.result       = result_q;
    assign bus.zero         = zero_q;
    assign bus.branch_taken = taken_q;

    // Decode the incoming request: single-cycle ALU value and branch condition.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can leave
        // a variable unassigned, which would otherwise infer a latch.
        alu_res    = bus.op_a + bus.op_b;
        is_shift   = 1'b0;
        shift_left = 1'b0;
        shamt      = bus.op_b[SHW-1:0];
        br_cond    = 1'b0;

        case (alu_op_e'(bus.alu_op_res))
            OP_AND:  alu_res = bus.op_a & bus.op_b;
            OP_OR:   alu_res = bus.op_a | bus.op_b;
            OP_XOR:  alu_res = bus.op_a ^ bus.op_b;
            OP_SUB:  alu_res = bus.op_a - bus.op_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.op_a < bus.op_b)};
            OP_SLL, OP_SLLI: begin
                // A zero shift amount finishes immediately with op_a unchanged.
                alu_res    = bus.op_a;
                is_shift   = 1'b1;
                shift_left = 1'b1;
            end
            OP_SRL, OP_SRLI: begin
                alu_res  = bus.op_a;
                is_shift = 1'b1;
            end
            default: alu_res = bus.op_a + bus.op_b;
        endcase

        // Branch compare uses the raw operands, independent of the ALU op.
        case (bus.branch)
            3'b000:  br_cond = (bus.op_a == bus.op_b);
            3'b001:  br_cond = (bus.op_a != bus.op_b);
            3'b010:  br_cond = 1'b1;
            3'b100:  br_cond = ($signed(bus.op_a) <  $signed(bus.op_b));
            3'b101:  br_cond = ($signed(bus.op_a) >= $signed(bus.op_b));
            3'b110:  br_cond = (bus.op_a <  bus.op_b);
            3'b111:  br_cond = (bus.op_a >= bus.op_b);
            default: br_cond = 1'b0;
        endcase
    end

    // Next-state logic: accept, serial shift stepping, and result retirement.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        taken_d  = taken_q;
        cnt_d    = cnt_q;
        left_d   = left_q;

        if (state_q == S_SHIFT) begin
            result_d = left_q ? (result_q << 1) : (result_q >> 1);
            cnt_d    = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
                state_d = S_DONE;
            end
        end else if (accept) begin
            taken_d  = bus.branch_en && br_cond;
            result_d = alu_res;
            if (is_shift && (shamt != '0)) begin
                cnt_d   = shamt;
                left_d  = shift_left;
                state_d = S_SHIFT;
            end else begin
                state_d = S_DONE;
            end
        end else if ((state_q == S_DONE) && bus.out_ready) begin
            state_d = S_IDLE;
        end

        zero_d = (result_d == '0);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (!reset_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            taken_q  <= 1'b0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            taken_q  <= taken_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors push hand-computed
// expectations; a monitor pops and compares on every result handshake.
module tb_alu_exec_unit;
    localparam int WIDTH = 32;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        zero;
        logic        taken;
    } exp_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    alu_exec_unit_if #(.WIDTH(WIDTH)) bus();

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every result handshake must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_result"}, bus.result, e.res);
                    check({e.name, "_zero"}, {31'd0, bus.zero}, {31'd0, e.zero});
                    check({e.name, "_taken"}, {31'd0, bus.branch_taken}, {31'd0, e.taken});
                end
            end
        end
    end

    task automatic push_exp(input string name, input logic [31:0] res, input logic taken);
        exp_t e;
        e.name  = name;
        e.res   = res;
        e.zero  = (res == 32'd0);
        e.taken = taken;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] br, input logic ben,
                         input logic [31:0] a, input logic [31:0] b);
        bus.in_valid   = 1'b1;
        bus.alu_op_res = op;
        bus.branch     = br;
        bus.branch_en  = ben;
        bus.op_a       = a;
        bus.op_b       = b;
    endtask

    // Present a request and return just after the edge that accepts it.
    task automatic issue(input string name, input logic [3:0] op, input logic [2:0] br,
                         input logic ben, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic taken, input bit push);
        int n;
        @(posedge clk);
        #1;
        drive(op, br, ben, a, b);
        if (push) push_exp(name, res, taken);
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check({name, "_accept_timeout"}, 32'd1, 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Count cycles from accept until out_valid; note any in_ready seen meanwhile.
    task automatic wait_done(output int cyc, output bit rdy_seen);
        cyc      = 1;
        rdy_seen = 1'b0;
        @(negedge clk);
        while (!bus.out_valid && cyc < 100) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        bit rdy;
        bit seen;
        checks         = 0;
        errors         = 0;
        reset_n        = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus.alu_op_res = 4'd0;
        bus.branch     = 3'b011;
        bus.branch_en  = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;

        // Power-on reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("por_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("por_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("por_result", bus.result, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset in the middle of SLL by 20 aborts it.
        issue("sll20", 4'b0100, 3'b011, 1'b0, 32'd1, 32'd20, 32'd0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_result", bus.result, 32'd0);
        check("rst_zero", {31'd0, bus.zero}, 32'd1);
        check("rst_taken", {31'd0, bus.branch_taken}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("rst_abort", {31'd0, seen}, 32'd0);

        // ADD then SUB back-to-back with no bubble.
        @(posedge clk);
        #1;
        drive(4'b0010, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1);
        push_exp("add_wrap", 32'h0, 1'b0);
        @(negedge clk);
        check("add_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        drive(4'b0110, 3'b011, 1'b0, 32'd5, 32'd7);
        push_exp("sub_neg", 32'hFFFF_FFFE, 1'b0);
        @(negedge clk);
        check("add_latency", {31'd0, bus.out_valid}, 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("sub_no_bubble", {31'd0, bus.out_valid}, 32'd1);

        // Serial shifts.
        issue("sll31", 4'b0100, 3'b011, 1'b0, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b1);
        wait_done(cyc, rdy);
        check("sll31_latency", cyc, 32'd32);
        check("sll31_in_ready_low", {31'd0, rdy}, 32'd0);
        issue("srli0", 4'b1010, 3'b011, 1'b0, 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b0, 1'b1);
        wait_done(cyc, rdy);
        check("srli0_latency", cyc, 32'd1);
        issue("srl4", 4'b0101, 3'b011, 1'b0, 32'h0000_00F0, 32'h0000_0024, 32'h0000_000F, 1'b0, 1'b1);
        wait_done(cyc, rdy);
        check("srl4_latency", cyc, 32'd5);
        issue("slli3", 4'b1001, 3'b011, 1'b0, 32'hA000_0001, 32'd3, 32'h0000_0008, 1'b0, 1'b1);
        wait_done(cyc, rdy);

        // Logic, compares and the default-to-ADD code.
        issue("and", 4'b0000, 3'b011, 1'b0, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0, 1'b1);
        issue("or", 4'b0001, 3'b011, 1'b0, 32'hF0F0, 32'h0FF0, 32'hFFF0, 1'b0, 1'b1);
        issue("slt", 4'b0111, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b1);
        issue("sltu", 4'b1000, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1);
        issue("op_1111", 4'b1111, 3'b011, 1'b0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1);

        // Branches.
        issue("beq", 4'b0110, 3'b000, 1'b1, 32'd7, 32'd7, 32'd0, 1'b1, 1'b1);
        issue("bne", 4'b0110, 3'b001, 1'b1, 32'd7, 32'd7, 32'd0, 1'b0, 1'b1);
        issue("bgeu", 4'b0110, 3'b111, 1'b1, 32'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
        issue("blt", 4'b0110, 3'b100, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b1, 1'b1);
        issue("jal", 4'b0010, 3'b010, 1'b1, 32'h100, 32'h20, 32'h120, 1'b1, 1'b1);
        issue("jal_off", 4'b0010, 3'b010, 1'b0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b1);
        issue("br_011", 4'b0010, 3'b011, 1'b1, 32'd1, 32'd1, 32'd2, 1'b0, 1'b1);

        // Backpressure: result holds and no new request enters.
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        issue("xor", 4'b0011, 3'b011, 1'b0, 32'hF0F0, 32'h0FF0, 32'hFF00, 1'b0, 1'b1);
        drive(4'b0010, 3'b011, 1'b0, 32'd1, 32'd1);
        push_exp("add_after_bp", 32'd2, 1'b0);
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_result", bus.result, 32'hFF00);
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;

        repeat (5) @(posedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle integer execute unit that consumes the 4-bit ALU operation code and 3-bit branch code produced by the ALU control decoder and returns the arithmetic result plus a branch-taken decision. It sits between the decoder/register-read stage and the writeback/PC-select logic of the single-issue RISC-V core. Single-cycle operations complete in one cycle. Shifts run serially, one bit per cycle, to save area. A valid/ready handshake on both sides lets the main control unit stall around multi-cycle shifts.

## Interface
- WIDTH, 32, datapath width; shift amount field is log2(WIDTH) bits (5 at default)
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request this cycle
- alu_op_res  input  4  operation code: AND=0000, OR=0001, ADD=0010, XOR=0011, SLL=0100, SRL=0101, SUB=0110, SLT=0111, SLTU=1000, SLLI=1001, SRLI=1010; all other codes execute as ADD
- branch  input  3  branch code: 000 BEQ, 001 BNE, 010 JAL (always taken), 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 011 never taken
- branch_en  input  1  branch code is meaningful; when 0, branch_taken is 0
- op_a  input  WIDTH  first operand (rs1 or PC)
- op_b  input  WIDTH  second operand (rs2 or immediate)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  ALU result
- zero  output  1  result == 0
- branch_taken  output  1  branch decision for the accepted request

## Operation
- Accept occurs on a cycle with in_valid && in_ready. On accept, capture op code, branch, branch_en, op_a and op_b into internal registers.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Transitions on accept:
  - non-shift op: go to DONE with result computed that cycle.
  - shift op (SLL, SRL, SLLI, SRLI) with shamt = op_b[log2(WIDTH)-1:0] > 0: load op_a into the shift register and shamt into a down-counter, then go to SHIFT.
  - shift op with shamt == 0: go to DONE with result = op_a.
- SHIFT: each cycle, shift 1 bit (left for SLL/SLLI, logical right for SRL/SRLI) and decrement the counter. When the counter reaches 1, perform the last shift and go to DONE.
- DONE with out_ready=1:
  - if in_valid is also high, accept the new request in the same cycle (back-to-back).
  - otherwise return to IDLE.
- DONE with out_ready=0: hold result, zero and branch_taken stable; accept nothing.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
  - SLT is a signed compare, SLTU an unsigned compare; the result is zero-extended 0 or 1.
- Branch decision:
  - computed from the captured op_a and op_b compared directly (signed for BLT/BGE, unsigned for BLTU/BGEU), independent of alu_op_res.
  - JAL gives taken=1 and result=op_a+op_b when the decoder supplies ADD.
  - branch_en=0 forces taken=0.
- Reset (reset_n=0 at a clock edge, including mid-SHIFT or in DONE):
  - go to IDLE and abort any operation.
  - result=0, zero=1, branch_taken=0, out_valid=0, in_ready=1 after the edge.

## Timing
- Non-shift latency: accept at edge N, out_valid=1 after edge N+1.
- Shift latency: 1 + shamt cycles from accept to out_valid; maximum WIDTH cycles (shamt = WIDTH-1).
- Throughput:
  - one non-shift op per cycle while out_ready is held high.
  - shifts block new accepts until DONE.
- All outputs are registered; in_ready is combinational only from state and out_ready.
- Inputs are sampled only on the accept cycle; changes at other times have no effect.

## Test plan
- Reset: hold reset_n=0 for 2 cycles during a SLL with shamt=20 -> IDLE, out_valid=0, in_ready=1, result=0, zero=1.
- ADD/SUB back-to-back with out_ready=1:
  - ADD 0xFFFFFFFF+1 -> result=0, zero=1, out_valid after 1 cycle.
  - next-cycle SUB 5-7 -> result=0xFFFFFFFE, no bubble between results.
- Serial shifts:
  - SLL op_a=1, op_b=31 -> result=0x80000000, out_valid after exactly 32 cycles; in_ready=0 throughout.
  - SRLI 0x80000000 by 0 -> result=0x80000000 after 1 cycle.
- Compares: SLT 0xFFFFFFFF vs 1 -> result=1; SLTU with the same operands -> result=0.
- Branches:
  - BEQ (alu_op_res=0110, branch=000, branch_en=1) with 7,7 -> taken=1, zero=1.
  - BGEU 1 vs 0xFFFFFFFF -> taken=0.
  - JAL op_a=0x100, op_b=0x20 -> taken=1, result=0x120.
  - branch_en=0 with branch=010 -> taken=0.
- Backpressure: out_ready=0 for 5 cycles after XOR 0xF0F0 ^ 0x0FF0 -> result holds 0xFF00, in_ready=0, a new in_valid is not accepted until out_ready rises.
